// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers of the 5-stage RISC-V core.
// Contents:
//   - payload field widths (REG_ADDR_W, XLEN) and the default payload width PAYLOAD_W
//   - packed per-stage payload typedef (MEM/WB shown; other stages follow the same pattern)
//   - stage occupancy encoding: {out_valid, skid_valid}
package pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // {wR, wD, pc, rf_we}
  localparam int PAYLOAD_W  = REG_ADDR_W + XLEN + XLEN + 1;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wr;
    logic [XLEN-1:0]       wd;
    logic [XLEN-1:0]       pc;
    logic                  rf_we;
  } mem_wb_payload_t;

  // The encoding is exactly the pair of valid flops, so no separate state register exists.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk   - clock
//   rst   - asynchronous, active-high reset (clears count)
//   inc   - increment request for this cycle
//   count - current value; holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
// Parameters:
//   DATA_W         - payload width
//   SKID_EN        - 0: single register, combinational in_ready
//                    1: main + skid register, in_ready straight from a flop
//   CLEAR_ON_FLUSH - 1: flush also zeroes the data registers
//   CNT_W          - stall counter width
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   flush               - synchronous kill of held and incoming entries
//   in_valid/in_ready   - upstream handshake, in_data payload
//   out_valid/out_ready - downstream handshake, out_data payload (out_valid = trace have_inst)
//   stall_cnt           - saturating count of cycles with out_valid && !out_ready
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W         = PAYLOAD_W,
  parameter int SKID_EN        = 1,
  parameter int CLEAR_ON_FLUSH = 0,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic              xfer_in;
  logic              xfer_out;

  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic         in_ready_q;
      stage_state_e state;

      assign state    = stage_state_e'({out_valid, skid_valid});
      assign in_ready = in_ready_q;

      // NOTE: the data registers are reset as well as the valids, because
      // out_data must read zero after reset; no memory array is involved.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
          in_ready_q <= 1'b1;
          out_data   <= '0;
          skid_data  <= '0;
        end else if (flush) begin
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
          in_ready_q <= 1'b1;
          if (CLEAR_ON_FLUSH != 0) begin
            out_data  <= '0;
            skid_data <= '0;
          end
        end else begin
          case (state)
            ST_EMPTY: begin
              if (xfer_in) begin
                out_data  <= in_data;
                out_valid <= 1'b1;
              end
            end
            ST_FULL: begin
              if (xfer_in && xfer_out) begin
                out_data <= in_data;
              end else if (xfer_out) begin
                out_valid <= 1'b0;
              end else if (xfer_in) begin
                // Downstream stalled while upstream still believed we were ready:
                // park the entry so in_ready can drop a cycle late.
                skid_data  <= in_data;
                skid_valid <= 1'b1;
                in_ready_q <= 1'b0;
              end
            end
            ST_SKID: begin
              if (xfer_out) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
              end
            end
            default: begin
              // (0,1) cannot be reached; the assertion below flags it.
            end
          endcase
        end
      end

      a_no_orphan_skid : assert property (@(posedge clk) disable iff (rst)
        !(skid_valid && !out_valid));

    end else begin : g_single
      assign in_ready   = out_ready || !out_valid;
      assign skid_valid = 1'b0;
      assign skid_data  = '0;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else if (flush) begin
          out_valid <= 1'b0;
          if (CLEAR_ON_FLUSH != 0) begin
            out_data <= '0;
          end
        end else if (xfer_in) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else if (xfer_out) begin
          out_valid <= 1'b0;
        end
      end
    end
  endgenerate

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid && !out_ready && !flush),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid. Two instances share one stimulus:
//   u_a : SKID_EN=1, CLEAR_ON_FLUSH=1, CNT_W=4
//   u_b : SKID_EN=0, CLEAR_ON_FLUSH=0, CNT_W=16
// Each instance is compared every cycle against a queue model of the stage
// (occupancy, head payload, readiness, saturating stall count), plus directed checks.
module tb_pipe_stage_skid;

  localparam int DW    = 70;
  localparam int A_MAX = 15;
  localparam int B_MAX = 65535;

  typedef logic [DW-1:0] word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  word_t       in_data = '0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid;
  word_t       a_out_data;
  logic [3:0]  a_stall;
  logic        b_in_ready, b_out_valid;
  word_t       b_out_data;
  logic [15:0] b_stall;

  int errors = 0;
  int checks = 0;

  // Reference model state
  word_t qa[$];
  word_t qb[$];
  word_t hold_a = '0;
  word_t hold_b = '0;
  int    cnt_a = 0;
  int    cnt_b = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W (DW), .SKID_EN (1), .CLEAR_ON_FLUSH (1), .CNT_W (4)
  ) u_a (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (a_in_ready), .in_data (in_data),
    .out_valid (a_out_valid), .out_ready (out_ready), .out_data (a_out_data),
    .stall_cnt (a_stall)
  );

  pipe_stage_skid #(
    .DATA_W (DW), .SKID_EN (0), .CLEAR_ON_FLUSH (0), .CNT_W (16)
  ) u_b (
    .clk (clk), .rst (rst), .flush (flush),
    .in_valid (in_valid), .in_ready (b_in_ready), .in_data (in_data),
    .out_valid (b_out_valid), .out_ready (out_ready), .out_data (b_out_data),
    .stall_cnt (b_stall)
  );

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    hold_a = '0;
    hold_b = '0;
    cnt_a  = 0;
    cnt_b  = 0;
  endtask

  task automatic check_outputs();
    chk("a_out_valid", word_t'(a_out_valid), word_t'(qa.size() > 0));
    chk("a_out_data",  a_out_data, (qa.size() > 0) ? qa[0] : hold_a);
    chk("a_in_ready",  word_t'(a_in_ready), word_t'(qa.size() < 2));
    chk("a_stall_cnt", word_t'(a_stall), word_t'(cnt_a));
    chk("b_out_valid", word_t'(b_out_valid), word_t'(qb.size() > 0));
    chk("b_out_data",  b_out_data, (qb.size() > 0) ? qb[0] : hold_b);
    chk("b_in_ready",  word_t'(b_in_ready), word_t'((qb.size() == 0) || out_ready));
    chk("b_stall_cnt", word_t'(b_stall), word_t'(cnt_b));
  endtask

  // One clock cycle of the behavioural stage: pop, push, flush, count.
  task automatic model_step();
    bit va, vb, ira, irb;
    va  = qa.size() > 0;
    ira = qa.size() < 2;
    vb  = qb.size() > 0;
    irb = (qb.size() == 0) || out_ready;
    if (flush) begin
      qa.delete();
      hold_a = '0;
      if (vb) hold_b = qb[0];
      qb.delete();
    end else begin
      if (va && !out_ready && cnt_a < A_MAX) cnt_a++;
      if (va && out_ready) hold_a = qa.pop_front();
      if (in_valid && ira) qa.push_back(in_data);
      if (vb && !out_ready && cnt_b < B_MAX) cnt_b++;
      if (vb && out_ready) hold_b = qb.pop_front();
      if (in_valid && irb) qb.push_back(in_data);
    end
  endtask

  // Inputs change 1 time unit after posedge; outputs are compared at negedge.
  task automatic tick();
    @(negedge clk);
    if (rst) model_reset();
    check_outputs();
    if (!rst) model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset with in_valid high
    in_valid = 1'b1;
    in_data  = word_t'(70'h3F);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_a_out_valid", word_t'(a_out_valid), '0);
    chk("rst_a_out_data", a_out_data, '0);
    chk("rst_a_in_ready", word_t'(a_in_ready), word_t'(1'b1));
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("post_rst_a_stall", word_t'(a_stall), '0);
    chk("post_rst_a_in_ready", word_t'(a_in_ready), word_t'(1'b1));
    tick();

    // 2. Back-to-back streaming, out_ready=1
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = word_t'(i);
      tick();
      chk("stream_a_out_data", a_out_data, word_t'(i));
      chk("stream_a_in_ready", word_t'(a_in_ready), word_t'(1'b1));
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_a_stall", word_t'(a_stall), '0);

    // 3. Backpressure into the skid register
    in_valid = 1'b1; in_data = word_t'(8'h10); out_ready = 1'b1;
    tick();
    in_data = word_t'(8'h11); out_ready = 1'b0;
    tick();
    chk("bp_a_out_data", a_out_data, word_t'(8'h10));
    chk("bp_a_skid_data", u_a.skid_data, word_t'(8'h11));
    chk("bp_a_in_ready", word_t'(a_in_ready), '0);
    in_data = word_t'(8'h12);
    for (int i = 0; i < 3; i++) tick();
    chk("bp_a_stall", word_t'(a_stall), word_t'(4));
    chk("bp_a_hold_data", a_out_data, word_t'(8'h10));
    out_ready = 1'b1;
    tick();
    chk("bp_a_second", a_out_data, word_t'(8'h11));
    tick();
    in_valid = 1'b0;
    chk("bp_a_third", a_out_data, word_t'(8'h12));
    chk("bp_a_third_valid", word_t'(a_out_valid), word_t'(1'b1));
    tick();
    chk("bp_a_drained", word_t'(a_out_valid), '0);
    chk("bp_a_stall_kept", word_t'(a_stall), word_t'(4));

    // 4. Flush in SKID state with a same-cycle incoming entry
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = word_t'(8'h30);
    tick();
    in_data = word_t'(8'h31);
    tick();
    flush = 1'b1; in_data = word_t'(8'h20);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_a_out_valid", word_t'(a_out_valid), '0);
    chk("flush_a_in_ready", word_t'(a_in_ready), word_t'(1'b1));
    chk("flush_a_out_data", a_out_data, '0);
    chk("flush_a_skid_data", u_a.skid_data, '0);
    chk("flush_a_stall", word_t'(a_stall), word_t'(5));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_a_no_0x20", word_t'(a_out_valid), '0);
    end

    // 5. Stall counter saturation (CNT_W=4)
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = word_t'(8'h40);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_a_stall", word_t'(a_stall), word_t'(15));
    tick();
    tick();
    chk("sat_a_stall_hold", word_t'(a_stall), word_t'(15));
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // 6. Single-register mode with toggling out_ready and continuous in_valid
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data   = word_t'(8'h50 + i);
      out_ready = (i % 2 == 0);
      #1;
      if (b_out_valid) chk("b_in_ready_mirror", word_t'(b_in_ready), word_t'(out_ready));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // Reset in the middle of a backpressured burst
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = word_t'(8'h60 + i);
      tick();
    end
    rst = 1'b1;
    #1;
    chk("midrst_a_out_valid", word_t'(a_out_valid), '0);
    chk("midrst_a_in_ready", word_t'(a_in_ready), word_t'(1'b1));
    chk("midrst_a_stall", word_t'(a_stall), '0);
    chk("midrst_b_out_valid", word_t'(b_out_valid), '0);
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = word_t'({$urandom, $urandom, $urandom});
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(24) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Parametrised pipeline-stage register for the 5-stage RISC-V core. It replaces the fixed per-stage registers (IF/ID … MEM/WB). It carries an opaque payload (wR, wD, pc, rf_we packed by the instantiating stage), with a valid bit that also serves as the trace "have_inst" flag. It adds a valid/ready handshake, synchronous flush, an optional 2-entry skid mode that registers the upstream ready, and a saturating stall-cycle counter for trace and performance reporting.

Parameters:
DATA_W, 70, payload width in bits (5 wR + 32 wD + 32 pc + 1 rf_we by default).
SKID_EN, 1, 0 = single register with combinational in_ready; 1 = main + skid register with registered in_ready.
CLEAR_ON_FLUSH, 0, 1 = flush also zeroes the data registers; 0 = only the valid bits are cleared.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  upstream entry present
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream payload
out_valid  out  1  downstream entry present (trace have_inst)
out_ready  in  1  downstream accepts this cycle
out_data  out  DATA_W  downstream payload
stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

Behaviour:
- Reset: asynchronous on rst. Required values while and after reset:
  - out_valid=0, out_data=0, skid_valid=0, skid_data=0, stall_cnt=0.
  - in_ready=1 for SKID_EN=1 (register reset to 1); for SKID_EN=0 in_ready is derived as below.
- Handshake:
  - Transfer in occurs when in_valid && in_ready.
  - Transfer out occurs when out_valid && out_ready.
  - out_data stays stable while out_valid && !out_ready.
- SKID_EN=0:
  - in_ready = out_ready || !out_valid (combinational).
  - On transfer in: out_data <= in_data, out_valid <= 1.
  - On transfer out with no transfer in: out_valid <= 0.
  - Latency 1 cycle; full throughput.
- SKID_EN=1, states are encoded by (out_valid, skid_valid):
  - EMPTY (0,0): a transfer in moves to FULL, loading the main register. in_ready=1.
  - FULL (1,0):
    - Transfer in and transfer out together: stay in FULL, main register reloads.
    - Transfer out only: go to EMPTY.
    - Transfer in only: go to SKID; the payload is captured in the skid register and in_ready <= 0.
  - SKID (1,1): in_ready=0. On transfer out, main <= skid, skid_valid <= 0, go to FULL, in_ready <= 1.
  - (0,1) is unreachable and treated as an assertion failure.
  - Latency 1 cycle; full throughput; in_ready is a pure flop output.
- Flush:
  - Has priority over every other event.
  - Next cycle: out_valid=0, skid_valid=0, in_ready=1, state EMPTY.
  - A same-cycle in_valid is dropped.
  - Data registers are zeroed only if CLEAR_ON_FLUSH=1.
  - stall_cnt is not affected.
- stall_cnt:
  - Increments by 1 on every cycle with out_valid && !out_ready && !flush.
  - Saturates at 2^CNT_W−1; no wrap.
  - Cleared only by rst.
- Reset mid-operation: all contents are discarded immediately; no partial transfer is reported.
- A bubble is an entry with out_valid=0. The downstream stage gates rf_we with out_valid.

Decomposition:
- Shared package pipe_pkg:
  - Payload field widths (REG_ADDR_W=5, XLEN=32).
  - Default DATA_W.
  - Packed payload typedef per stage, e.g. mem_wb_payload_t = {wR, wD, pc, rf_we}.
  - State encoding constants ST_EMPTY, ST_FULL, ST_SKID.
- One natural sub-module: sat_counter (CNT_W-wide saturating incrementer), instantiated for stall_cnt.

Test Plan:
1. Reset then idle: assert rst for 3 cycles with in_valid=1 → out_valid=0, out_data=0, stall_cnt=0, in_ready=1 during and after reset.
2. Streaming, SKID_EN=1, out_ready=1: send payloads 0x01..0x08 back-to-back → each appears one cycle later in order, in_ready stays 1, stall_cnt stays 0.
3. Backpressure: stream 0x10, 0x11, 0x12 and drop out_ready at the second transfer for 4 cycles →
   - out_data holds 0x10 and the skid register holds 0x11.
   - in_ready=0 from the next cycle.
   - After release, 0x10, 0x11, 0x12 are delivered in order with no loss or duplicate.
   - stall_cnt=4.
4. Flush in the SKID state, with in_valid=1 carrying 0x20 in the same cycle → next cycle out_valid=0, in_ready=1, 0x20 is never emitted; with CLEAR_ON_FLUSH=1, out_data=0.
5. Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt reaches 15 and stays at 15.
6. SKID_EN=0, out_ready toggling 1,0,1,0 with continuous in_valid → in_ready mirrors out_ready whenever out_valid=1, and every accepted payload is delivered exactly once.
